// File: rtl/sha_msg_sched.sv
// SHA-256/SHA-512 message-schedule generator: loads a padded block and streams W[0..ROUNDS-1].
// Optional block prefetch buffer is compiled in with `define SHA_MSG_SCHED_PREFETCH_EN.
//
// state | meaning
// IDLE  | waiting for a padded block
// RUN   | producing schedule words
// DRAIN | last word presented, waiting for its handshake
module sha_msg_sched #(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 7
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   blk_valid_i,
    input  logic [16*WORD_W-1:0]   blk_data_i,
    output logic                   blk_ready_o,
    input  logic                   abort_i,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [WORD_W-1:0]      w_data_o,
    output logic [IDX_W-1:0]       w_idx_o,
    output logic                   w_last_o
);

    localparam int ROUNDS = (WORD_W == 32) ? 64 : 80;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
            $error("sha_msg_sched: WORD_W must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
        else              return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
        else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    state_t            state_q, state_d;
    logic [WORD_W-1:0] r_q [16];
    logic [WORD_W-1:0] r_d [16];
    logic [WORD_W-1:0] m_w [16];
    logic [WORD_W-1:0] wn;
    logic [IDX_W-1:0]  gen_q, gen_d;
    logic              w_valid_q, w_valid_d;
    logic [WORD_W-1:0] w_data_q, w_data_d;
    logic [IDX_W-1:0]  w_idx_q, w_idx_d;
    logic              w_last_q, w_last_d;
    logic              blk_fire;
    logic              produce;

`ifdef SHA_MSG_SCHED_PREFETCH_EN
    logic [WORD_W-1:0] buf_q [16];
    logic [WORD_W-1:0] buf_d [16];
    logic              full_q, full_d;

    assign blk_ready_o = (state_q == IDLE) || !full_q;
`else
    assign blk_ready_o = (state_q == IDLE);
`endif

    always_comb begin
        for (int i = 0; i < 16; i++) m_w[i] = blk_data_i[(15-i)*WORD_W +: WORD_W];
    end

    assign wn       = sig1(r_q[14]) + r_q[9] + sig0(r_q[1]) + r_q[0];
    assign blk_fire = blk_valid_i && blk_ready_o;
    assign produce  = (state_q == RUN) && (!w_valid_q || w_ready_i);

    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        gen_d     = gen_q;
        w_valid_d = w_valid_q;
        w_data_d  = w_data_q;
        w_idx_d   = w_idx_q;
        w_last_d  = w_last_q;
`ifdef SHA_MSG_SCHED_PREFETCH_EN
        buf_d  = buf_q;
        full_d = full_q;
        if (state_q != IDLE && blk_fire) begin
            buf_d  = m_w;
            full_d = 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (blk_fire) begin
                    r_d     = m_w;
                    gen_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (produce) begin
                    w_valid_d = 1'b1;
                    w_data_d  = r_q[0];
                    w_idx_d   = gen_q;
                    w_last_d  = (gen_q == LAST_IDX);
                    for (int i = 0; i < 15; i++) r_d[i] = r_q[i+1];
                    r_d[15] = wn;
                    gen_d   = gen_q + 1'b1;
                    if (gen_q == LAST_IDX) begin
                        state_d = DRAIN;
`ifdef SHA_MSG_SCHED_PREFETCH_EN
                        // A block arriving on this very edge goes straight into R.
                        if (full_d) begin
                            r_d     = full_q ? buf_q : m_w;
                            gen_d   = '0;
                            full_d  = 1'b0;
                            state_d = RUN;
                        end
`endif
                    end
                end
            end
            DRAIN: begin
                if (w_valid_q && w_ready_i) begin
                    w_valid_d = 1'b0;
                    w_last_d  = 1'b0;
                    state_d   = IDLE;
`ifdef SHA_MSG_SCHED_PREFETCH_EN
                    if (full_d) begin
                        r_d     = full_q ? buf_q : m_w;
                        gen_d   = '0;
                        full_d  = 1'b0;
                        state_d = RUN;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d   = IDLE;
            w_valid_d = 1'b0;
            w_last_d  = 1'b0;
`ifdef SHA_MSG_SCHED_PREFETCH_EN
            full_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            r_q       <= '{default: '0};
            gen_q     <= '0;
            w_valid_q <= 1'b0;
            w_data_q  <= '0;
            w_idx_q   <= '0;
            w_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            gen_q     <= gen_d;
            w_valid_q <= w_valid_d;
            w_data_q  <= w_data_d;
            w_idx_q   <= w_idx_d;
            w_last_q  <= w_last_d;
        end
    end

`ifdef SHA_MSG_SCHED_PREFETCH_EN
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            buf_q  <= '{default: '0};
            full_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            full_q <= full_d;
        end
    end
`endif

    assign w_valid_o = w_valid_q;
    assign w_data_o  = w_data_q;
    assign w_idx_o   = w_idx_q;
    assign w_last_o  = w_last_q;

endmodule

// File: tb/tb_sha_msg_sched.sv
// Scoreboard bench for sha_msg_sched: 32-bit and 64-bit instances checked against
// a textbook W[t] recurrence computed over a whole array.
module tb_sha_msg_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          blk_valid32, blk_ready32, abort32, w_valid32, w_ready32, w_last32;
    logic [511:0]  blk_data32;
    logic [31:0]   w_data32;
    logic [6:0]    w_idx32;
    logic          blk_valid64, blk_ready64, abort64, w_valid64, w_ready64, w_last64;
    logic [1023:0] blk_data64;
    logic [63:0]   w_data64;
    logic [6:0]    w_idx64;

    sha_msg_sched #(.WORD_W(32), .IDX_W(7)) u_dut32 (
        .clock_i(clk), .reset_i(rst), .blk_valid_i(blk_valid32), .blk_data_i(blk_data32),
        .blk_ready_o(blk_ready32), .abort_i(abort32), .w_valid_o(w_valid32), .w_ready_i(w_ready32),
        .w_data_o(w_data32), .w_idx_o(w_idx32), .w_last_o(w_last32));

    sha_msg_sched #(.WORD_W(64), .IDX_W(7)) u_dut64 (
        .clock_i(clk), .reset_i(rst), .blk_valid_i(blk_valid64), .blk_data_i(blk_data64),
        .blk_ready_o(blk_ready64), .abort_i(abort64), .w_valid_o(w_valid64), .w_ready_i(w_ready64),
        .w_data_o(w_data64), .w_idx_o(w_idx64), .w_last_o(w_last64));

    typedef struct { logic [63:0] d; int idx; logic last; } exp_t;
    exp_t exp32_q[$];
    exp_t exp64_q[$];

    int checks = 0;
    int errors = 0;
    int hs32 = 0, last32 = 0, hs64 = 0, last64 = 0;
    logic [63:0] cap32_16, cap32_17, cap64_16, cap64_17;
    logic rand_mode = 1'b0;

    logic [63:0] mm [16];
    logic [63:0] mw [80];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int ww);
        logic [63:0] m;
        m = (ww == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        x = x & m;
        return ((x >> n) | (x << (ww - n))) & m;
    endfunction

    function automatic logic [63:0] ssig0(input logic [63:0] x, input int ww);
        if (ww == 32) return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
        return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] ssig1(input logic [63:0] x, input int ww);
        if (ww == 32) return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
        return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
    endfunction

    // Full schedule from mm[] into mw[], then queue it as expected output.
    task automatic build_and_push(input int ww);
        int rounds;
        logic [63:0] m;
        exp_t e;
        rounds = (ww == 32) ? 64 : 80;
        m = (ww == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        for (int t = 0; t < 16; t++) mw[t] = mm[t] & m;
        for (int t = 16; t < rounds; t++)
            mw[t] = (ssig1(mw[t-2], ww) + mw[t-7] + ssig0(mw[t-15], ww) + mw[t-16]) & m;
        for (int t = 0; t < rounds; t++) begin
            e.d = mw[t]; e.idx = t; e.last = (t == rounds - 1);
            if (ww == 32) exp32_q.push_back(e);
            else          exp64_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) mm[i] = '0;
        mm[0]  = 64'h6162_6380;
        mm[15] = 64'h18;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) mm[i] = {32'($urandom), 32'($urandom)};
    endtask

    task automatic send32();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (blk_ready32) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL blk_ready_timeout: blk_ready stayed low for 300 cycles");
        end
        build_and_push(32);
        for (int i = 0; i < 16; i++) blk_data32[(15-i)*32 +: 32] = mm[i][31:0];
        blk_valid32 = 1'b1;
        tick();
        blk_valid32 = 1'b0;
    endtask

    task automatic wait_drain32();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (exp32_q.size() == 0 && !w_valid32) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain32_timeout: %0d words still expected", exp32_q.size());
        end
    endtask

    task automatic wait_idx32(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (w_valid32 && w_idx32 == 7'(k)) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_idx_timeout: index %0d never presented", k);
        end
    endtask

    initial begin
        w_ready32 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            w_ready32 = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    logic        stall32 = 1'b0;
    logic [31:0] prev_d32;
    logic [6:0]  prev_i32;
    logic        prev_l32;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && !abort32 && w_valid32) begin
            if (stall32) begin
                check("hold_data", 64'(w_data32), 64'(prev_d32));
                check("hold_idx", 64'(w_idx32), 64'(prev_i32));
                check("hold_last", 64'(w_last32), 64'(prev_l32));
            end
            if (w_ready32) begin
                hs32++;
                if (w_last32) last32++;
                if (w_idx32 == 7'd16) cap32_16 = 64'(w_data32);
                if (w_idx32 == 7'd17) cap32_17 = 64'(w_data32);
                if (exp32_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word32: idx %0d data %0h with nothing expected", w_idx32, w_data32);
                end else begin
                    e = exp32_q.pop_front();
                    check("w_data32", 64'(w_data32), e.d);
                    check("w_idx32", 64'(w_idx32), 64'(e.idx));
                    check("w_last32", 64'(w_last32), 64'(e.last));
                end
            end
        end
        stall32  = !rst && !abort32 && w_valid32 && !w_ready32;
        prev_d32 = w_data32;
        prev_i32 = w_idx32;
        prev_l32 = w_last32;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && !abort64 && w_valid64 && w_ready64) begin
            hs64++;
            if (w_last64) last64++;
            if (w_idx64 == 7'd16) cap64_16 = w_data64;
            if (w_idx64 == 7'd17) cap64_17 = w_data64;
            if (exp64_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_word64: idx %0d data %0h with nothing expected", w_idx64, w_data64);
            end else begin
                e = exp64_q.pop_front();
                check("w_data64", w_data64, e.d);
                check("w_idx64", 64'(w_idx64), 64'(e.idx));
                check("w_last64", 64'(w_last64), 64'(e.last));
            end
        end
    end

    initial begin
        #600000;
        checks++; errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1;
        blk_valid32 = 1'b0; blk_data32 = '0; abort32 = 1'b0;
        blk_valid64 = 1'b0; blk_data64 = '0; abort64 = 1'b0; w_ready64 = 1'b1;
        repeat (3) tick();
        check("rst_w_valid", 64'(w_valid32), 0);
        check("rst_w_data", 64'(w_data32), 0);
        check("rst_w_idx", 64'(w_idx32), 0);
        check("rst_w_last", 64'(w_last32), 0);
        check("rst_blk_ready", 64'(blk_ready32), 1);
        check("rst_blk_ready64", 64'(blk_ready64), 1);
        rst = 1'b0;
        tick();

        // 32-bit "abc" with latency and golden-constant checks
        set_abc();
        hs32 = 0; last32 = 0;
        send32();
        check("lat_e0_valid", 64'(w_valid32), 0);
`ifdef SHA_MSG_SCHED_PREFETCH_EN
        check("run_blk_ready", 64'(blk_ready32), 1);
`else
        check("run_blk_ready", 64'(blk_ready32), 0);
`endif
        tick();
        check("lat_e1_valid", 64'(w_valid32), 1);
        check("lat_e1_idx", 64'(w_idx32), 0);
        check("lat_e1_data", 64'(w_data32), 64'h6162_6380);
        wait_drain32();
        check("abc_handshakes", 64'(hs32), 64);
        check("abc_last_count", 64'(last32), 1);
        check("abc_w16", cap32_16, 64'h6162_6380);
        check("abc_w17", cap32_17, 64'h000F_0000);
        check("done_blk_ready", 64'(blk_ready32), 1);

        // 64-bit "abc"
        for (int i = 0; i < 16; i++) mm[i] = '0;
        mm[0]  = 64'h6162_6380_0000_0000;
        mm[15] = 64'h18;
        build_and_push(64);
        for (int i = 0; i < 16; i++) blk_data64[(15-i)*64 +: 64] = mm[i];
        blk_valid64 = 1'b1;
        tick();
        blk_valid64 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp64_q.size() == 0 && !w_valid64) break;
            tick();
        end
        check("abc64_remaining", 64'(exp64_q.size()), 0);
        check("abc64_handshakes", 64'(hs64), 80);
        check("abc64_last_count", 64'(last64), 1);
        check("abc64_w16", cap64_16, 64'h6162_6380_0000_0000);
        check("abc64_w17", cap64_17, 64'h0003_0000_0000_00C0);

        // Random backpressure, "abc" then random blocks
        rand_mode = 1'b1;
        hs32 = 0;
        set_abc();
        send32();
        wait_drain32();
        check("stall_handshakes", 64'(hs32), 64);
        for (int b = 0; b < 3; b++) begin
            set_random();
            send32();
        end
        wait_drain32();
        rand_mode = 1'b0;
        tick();

        // Abort mid-stream, then a fresh block
        set_random();
        send32();
        wait_idx32(20);
        abort32 = 1'b1;
        exp32_q.delete();
        tick();
        abort32 = 1'b0;
        check("abort_w_valid", 64'(w_valid32), 0);
        check("abort_w_last", 64'(w_last32), 0);
        check("abort_blk_ready", 64'(blk_ready32), 1);
        set_random();
        send32();
        wait_drain32();

        // Reset mid-stream with blk_valid held during reset
        set_random();
        send32();
        wait_idx32(40);
        rst = 1'b1;
        set_random();
        for (int i = 0; i < 16; i++) blk_data32[(15-i)*32 +: 32] = mm[i][31:0];
        blk_valid32 = 1'b1;
        exp32_q.delete();
        tick();
        check("mid_rst_w_valid", 64'(w_valid32), 0);
        check("mid_rst_w_data", 64'(w_data32), 0);
        check("mid_rst_w_idx", 64'(w_idx32), 0);
        check("mid_rst_w_last", 64'(w_last32), 0);
        check("mid_rst_blk_ready", 64'(blk_ready32), 1);
        rst = 1'b0;
        blk_valid32 = 1'b0;
        tick();
        tick();
        check("rst_blk_not_taken", 64'(w_valid32), 0);
        set_abc();
        send32();
        wait_drain32();

`ifdef SHA_MSG_SCHED_PREFETCH_EN
        begin
            int run, best;
            run = 0; best = 0;
            set_random();
            send32();
            set_random();
            send32();
            for (int i = 0; i < 140; i++) begin
                if (w_valid32) run++;
                else run = 0;
                if (run > best) best = run;
                tick();
            end
            check("prefetch_run", 64'(best), 128);
            wait_drain32();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
